// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared types and constants for the multi-lane I2S receiver
package i2s_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_SHIFT,
        ST_HOLD
    } i2s_state_e;

    localparam logic MODE_I2S = 1'b0;
    localparam logic MODE_LJ  = 1'b1;

    // Bit counter must hold any count from 0 up to a full slot.
    function automatic int cnt_width(input int slot_bits);
        return $clog2(slot_bits + 1);
    endfunction

endpackage

// File: rtl/i2s_lane_shift.sv
// rtl/i2s_lane_shift.sv - per-lane slot shift register, left staging and PCM output registers
module i2s_lane_shift #(
    parameter int SAMPLE_BITS = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sd,
    input  logic                   shift_en,
    input  logic                   latch_left,
    input  logic                   latch_frame,
    output logic [SAMPLE_BITS-1:0] pcm_left,
    output logic [SAMPLE_BITS-1:0] pcm_right
);

    logic [SAMPLE_BITS-1:0] shift_q;
    logic [SAMPLE_BITS-1:0] left_q;
    logic [SAMPLE_BITS-1:0] shift_next;

    // The LSB is still on sd when a slot completes, so latches take the post-shift value.
    generate
        if (SAMPLE_BITS == 1) begin : g_one
            assign shift_next = sd;
        end else begin : g_multi
            assign shift_next = {shift_q[SAMPLE_BITS-2:0], sd};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= '0;
            left_q    <= '0;
            pcm_left  <= '0;
            pcm_right <= '0;
        end else begin
            if (shift_en) begin
                shift_q <= shift_next;
            end
            if (latch_left) begin
                left_q <= shift_next;
            end
            if (latch_frame) begin
                pcm_left  <= left_q;
                pcm_right <= shift_next;
            end
        end
    end

endmodule

// File: rtl/i2s_rx_multilane.sv
// rtl/i2s_rx_multilane.sv - multi-lane I2S / left-justified receiver with valid/ready output
module i2s_rx_multilane
    import i2s_pkg::*;
#(
    parameter int NUM_LINES   = 4,
    parameter int SAMPLE_BITS = 8,
    parameter int SLOT_BITS   = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             enable,
    input  logic                             mode_lj,
    input  logic                             ws,
    input  logic [NUM_LINES-1:0]             sd,
    output logic [NUM_LINES*SAMPLE_BITS-1:0] pcm_left,
    output logic [NUM_LINES*SAMPLE_BITS-1:0] pcm_right,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             overflow,
    output logic                             frame_err,
    input  logic                             clear_flags
);

    localparam int CW = cnt_width(SLOT_BITS);
    localparam logic [CW-1:0] SB_C = CW'(SAMPLE_BITS);

    i2s_state_e    state;
    logic          ws_q;
    logic          mode_q;
    logic          slot_right;
    logic          left_ok;
    logic [CW-1:0] cnt;

    logic          ws_edge;
    logic          capturing;
    logic          start;
    logic          short_slot;
    logic          mode_cur;
    logic          shift_en;
    logic [CW-1:0] cnt_next;
    logic          done;
    logic          cur_right;
    logic          latch_left;
    logic          latch_frame;

    // DELAY marks the skipped I2S edge bit; from the following edge it captures like SHIFT.
    always_comb begin
        ws_edge     = ws ^ ws_q;
        capturing   = (state == ST_DELAY) || (state == ST_SHIFT);
        start       = enable && ws_edge && ((state != ST_IDLE) || !ws);
        short_slot  = enable && ws_edge && capturing;
        mode_cur    = (state == ST_IDLE) ? mode_lj : mode_q;
        shift_en    = enable && ((start && (mode_cur == MODE_LJ)) || (capturing && !ws_edge));
        cnt_next    = (start ? '0 : cnt) + CW'(1);
        done        = shift_en && (cnt_next == SB_C);
        cur_right   = start ? ws : slot_right;
        latch_left  = done && !cur_right;
        latch_frame = done && cur_right && left_ok && !short_slot;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ws_q       <= 1'b0;
            mode_q     <= MODE_I2S;
            slot_right <= 1'b0;
            left_ok    <= 1'b0;
            cnt        <= '0;
            out_valid  <= 1'b0;
            overflow   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            ws_q <= ws;
            if (!enable) begin
                state   <= ST_IDLE;
                left_ok <= 1'b0;
                cnt     <= '0;
            end else begin
                if (start) begin
                    slot_right <= ws;
                    mode_q     <= mode_cur;
                end
                if (shift_en) begin
                    cnt <= cnt_next;
                end else if (start) begin
                    cnt <= '0;
                end
                if (done) begin
                    state <= ST_HOLD;
                end else if (start) begin
                    state <= (mode_cur == MODE_LJ) ? ST_SHIFT : ST_DELAY;
                end else if (state == ST_DELAY) begin
                    state <= ST_SHIFT;
                end
                if (latch_left) begin
                    left_ok <= 1'b1;
                end else if (latch_frame || short_slot) begin
                    left_ok <= 1'b0;
                end
            end

            // A frame landing on a transfer edge keeps out_valid high without overflow.
            if (latch_frame) begin
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (latch_frame && out_valid && !out_ready) begin
                overflow <= 1'b1;
            end else if (clear_flags) begin
                overflow <= 1'b0;
            end

            if (short_slot) begin
                frame_err <= 1'b1;
            end else if (clear_flags) begin
                frame_err <= 1'b0;
            end
        end
    end

    generate
        for (genvar i = 0; i < NUM_LINES; i++) begin : g_lane
            i2s_lane_shift #(
                .SAMPLE_BITS(SAMPLE_BITS)
            ) u_lane (
                .clk        (clk),
                .rst_n      (rst_n),
                .sd         (sd[i]),
                .shift_en   (shift_en),
                .latch_left (latch_left),
                .latch_frame(latch_frame),
                .pcm_left   (pcm_left[i*SAMPLE_BITS +: SAMPLE_BITS]),
                .pcm_right  (pcm_right[i*SAMPLE_BITS +: SAMPLE_BITS])
            );
        end
    endgenerate

endmodule

// File: tb/tb_i2s_rx_multilane.sv
// tb/tb_i2s_rx_multilane.sv - self-checking bench for i2s_rx_multilane with a slot-level reference model
module tb_i2s_rx_multilane;

    localparam int NL = 2;
    localparam int SB = 8;
    localparam int SL = 16;
    localparam int W  = NL * SB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          mode_lj;
    logic          ws;
    logic [NL-1:0] sd;
    logic [W-1:0]  pcm_left;
    logic [W-1:0]  pcm_right;
    logic          out_valid;
    logic          out_ready;
    logic          overflow;
    logic          frame_err;
    logic          clear_flags;

    i2s_rx_multilane #(
        .NUM_LINES  (NL),
        .SAMPLE_BITS(SB),
        .SLOT_BITS  (SL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .mode_lj    (mode_lj),
        .ws         (ws),
        .sd         (sd),
        .pcm_left   (pcm_left),
        .pcm_right  (pcm_right),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .clear_flags(clear_flags)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0] l;
        logic [W-1:0] r;
        int           c;
    } frame_t;

    frame_t exp_q[$];
    frame_t obs_q[$];
    bit     mon_en = 1'b1;

    always @(negedge clk) begin
        if (mon_en && rst_n && out_valid && out_ready) begin
            obs_q.push_back('{pcm_left, pcm_right, cyc});
        end
    end

    int tests = 0;
    int fails = 0;

    bit           armed;
    bit           left_ok_m;
    bit           pending_short;
    bit           ferr_exp;
    logic [W-1:0] left_m;
    logic         prev_ws;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_idle();
        armed         = 1'b0;
        left_ok_m     = 1'b0;
        pending_short = 1'b0;
    endtask

    // One ws half-period of len bit clocks; word holds lane l at [l*SB +: SB], MSB first.
    task automatic drive_slot(input logic wsv, input logic [W-1:0] word, input int len);
        bit lj;
        bit complete;
        int p;
        lj       = mode_lj;
        complete = (len >= (lj ? SB : SB + 1));
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (i == 0 && wsv != prev_ws && enable) begin
                if (pending_short) begin
                    ferr_exp      = 1'b1;
                    left_ok_m     = 1'b0;
                    pending_short = 1'b0;
                end
                if (armed || !wsv) begin
                    armed = 1'b1;
                    if (!complete) begin
                        pending_short = 1'b1;
                    end else if (!wsv) begin
                        left_ok_m = 1'b1;
                        left_m    = word;
                    end else if (left_ok_m) begin
                        exp_q.push_back('{left_m, word, cyc + 1 + SB - int'(lj)});
                        left_ok_m = 1'b0;
                    end
                end
            end
            ws = wsv;
            p  = lj ? i : i - 1;
            sd = NL'($urandom);
            if (p >= 0 && p < SB) begin
                for (int l = 0; l < NL; l++) sd[l] = word[l*SB + SB - 1 - p];
            end
        end
        prev_ws = wsv;
    endtask

    task automatic hold_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            sd = NL'($urandom);
        end
    endtask

    task automatic check_frames(input string tag);
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check({tag, "_left"},  obs_q[i].l, exp_q[i].l);
            check({tag, "_right"}, obs_q[i].r, exp_q[i].r);
            check({tag, "_cycle"}, obs_q[i].c, exp_q[i].c);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    function automatic logic [W-1:0] rnd();
        return W'($urandom);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_pcm_left"},  pcm_left,  0);
        check({tag, "_pcm_right"}, pcm_right, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_overflow"},  overflow,  0);
        check({tag, "_frame_err"}, frame_err, 0);
    endtask

    initial begin
        frame_t last;
        rst_n       = 1'b0;
        enable      = 1'b0;
        mode_lj     = 1'b0;
        ws          = 1'b0;
        sd          = '0;
        out_ready   = 1'b1;
        clear_flags = 1'b0;
        prev_ws     = 1'b0;
        ferr_exp    = 1'b0;
        left_m      = '0;
        model_idle();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n  = 1'b1;
        @(negedge clk);
        enable = 1'b1;

        // I2S framing with the reference words, preceded by an ignored partial right slot.
        drive_slot(1'b1, rnd(), SL);
        drive_slot(1'b0, 16'h81A5, SL);
        drive_slot(1'b1, 16'h7E3C, SL);
        drive_slot(1'b0, rnd(), SL);
        check_frames("i2s_basic");

        // Switch to left-justified through IDLE.
        @(negedge clk);
        enable = 1'b0;
        model_idle();
        @(negedge clk);
        mode_lj = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        drive_slot(1'b1, rnd(), SL);
        drive_slot(1'b0, 16'h81A5, SL);
        drive_slot(1'b1, 16'h7E3C, SL);
        drive_slot(1'b0, rnd(), SL);
        check_frames("lj_basic");

        for (int n = 0; n < 3; n++) begin
            drive_slot(1'b1, rnd(), SL);
            drive_slot(1'b0, rnd(), SL);
        end
        check_frames("lj_random");

        // Back-pressure: three frames land with out_ready low.
        mon_en = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            drive_slot(1'b0, rnd(), SL);
            drive_slot(1'b1, rnd(), SL);
        end
        last = exp_q[$];
        check("ovf_frames_landed", exp_q.size(), 3);
        check("ovf_out_valid", out_valid, 1);
        check("ovf_pcm_left", pcm_left, last.l);
        check("ovf_pcm_right", pcm_right, last.r);
        check("ovf_flag", overflow, 1);
        @(negedge clk);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        check("ovf_cleared", overflow, 0);
        check("ovf_valid_kept", out_valid, 1);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("ovf_drained", out_valid, 0);
        mon_en = 1'b1;
        exp_q.delete();
        obs_q.delete();

        // Short left slot of five bits, then a clean frame.
        drive_slot(1'b0, rnd(), 5);
        drive_slot(1'b1, rnd(), SL);
        check("short_frame_err", frame_err, ferr_exp);
        check("short_frame_err_set", frame_err, 1);
        check_frames("short_dropped");
        drive_slot(1'b0, 16'h1234, SL);
        drive_slot(1'b1, 16'hABCD, SL);
        drive_slot(1'b0, rnd(), SL);
        check_frames("short_recover");
        @(negedge clk);
        clear_flags = 1'b1;
        ferr_exp    = 1'b0;
        @(negedge clk);
        clear_flags = 1'b0;
        check("ferr_cleared", frame_err, 0);

        // Asynchronous reset in the middle of a left slot.
        drive_slot(1'b1, rnd(), SL);
        drive_slot(1'b0, rnd(), 4);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        model_idle();
        ferr_exp = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive_slot(1'b1, rnd(), 9);
        drive_slot(1'b0, rnd(), SL);
        drive_slot(1'b1, rnd(), SL);
        drive_slot(1'b0, rnd(), SL);
        check_frames("after_reset");

        // Disable partway through a right slot.
        drive_slot(1'b1, rnd(), SL);
        drive_slot(1'b0, rnd(), SL);
        drive_slot(1'b1, rnd(), 4);
        enable = 1'b0;
        model_idle();
        hold_cycles(3);
        enable = 1'b1;
        hold_cycles(6);
        drive_slot(1'b0, rnd(), SL);
        drive_slot(1'b1, rnd(), SL);
        drive_slot(1'b0, rnd(), SL);
        check_frames("enable_gap");
        check("enable_no_ferr", frame_err, ferr_exp);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/i2s_rx_multilane.md
# i2s_rx_multilane

Parametrised multi-lane I2S receiver that deserialises NUM_LINES serial data lines sharing one bit clock and word-select into parallel left/right PCM words. It is the next generation of the single-lane I2S front end feeding the beamformer channel buffers. New capabilities:
- configurable sample and slot width
- I2S or left-justified framing
- valid/ready output handshake
- sticky overflow and framing-error flags

## Interface
Parameters:
- NUM_LINES, 4, number of serial data lines (each carries one stereo pair)
- SAMPLE_BITS, 8, bits captured per slot, MSB first; 1 ≤ SAMPLE_BITS ≤ SLOT_BITS
- SLOT_BITS, 32, nominal bit clocks per ws half-period; sizes the bit counter

Ports:
- clk  input  1  serial bit clock; all sampling on rising edge
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  0 forces IDLE; no capture
- mode_lj  input  1  0 = I2S (one-bit delay after ws edge), 1 = left-justified; sample only in IDLE
- ws  input  1  word select; 0 = left slot, 1 = right slot
- sd  input  NUM_LINES  serial data, bit i = lane i
- pcm_left  output  NUM_LINES*SAMPLE_BITS  lane i at [i*SAMPLE_BITS +: SAMPLE_BITS]
- pcm_right  output  NUM_LINES*SAMPLE_BITS  same packing
- out_valid  output  1  frame available
- out_ready  input  1  consumer accepts frame
- overflow  output  1  sticky: unaccepted frame overwritten
- frame_err  output  1  sticky: ws edge before SAMPLE_BITS captured
- clear_flags  input  1  synchronous clear of both sticky flags

## Operation
- ws edge: ws differs from ws_q, the registered ws of the previous edge. ws_q resets to 0.
- States:
  - IDLE: wait for a ws falling edge (start of left slot). Go to DELAY if mode_lj=0, else SHIFT, capturing the edge-cycle sd as MSB.
  - DELAY: one cycle, sd ignored → SHIFT.
  - SHIFT: shift sd into each lane's slot register; bit counter counts captured bits. At SAMPLE_BITS bits → HOLD.
  - HOLD: ignore sd until the next ws edge, then re-enter DELAY/SHIFT for the next slot.
- Slot completion:
  - Left completion latches the left staging register and sets left_ok.
  - Right completion with left_ok=1 loads pcm_left/pcm_right together, asserts out_valid, clears left_ok.
  - Right completion with left_ok=0 is discarded silently.
- ws edge in DELAY or SHIFT (short slot):
  - discard partial sample
  - set frame_err, clear left_ok
  - start capture of the new slot using the normal edge rule
- enable=0 in any state: IDLE next edge; left_ok cleared; out_valid and pcm outputs unaffected.
- clear_flags and a same-cycle flag set: set wins.

## Timing
- Reset values: pcm_left=0, pcm_right=0, out_valid=0, overflow=0, frame_err=0, state IDLE, counter 0, left_ok=0.
- I2S mode: ws edge sampled at edge k → MSB at edge k+1, LSB at edge k+SAMPLE_BITS.
- Left-justified mode: MSB at edge k, LSB at edge k+SAMPLE_BITS−1.
- Right LSB at edge e → pcm outputs and out_valid=1 visible after edge e; latency 1 clk from last bit.
- Handshake:
  - Transfer at any rising edge with out_valid & out_ready.
  - out_valid falls after that edge unless a new frame lands at the same edge. In that case out_valid stays 1, the new data is loaded, and no overflow is raised.
  - New frame landing while out_valid=1 & out_ready=0: overwrite data and set overflow.
- out_ready is ignored while out_valid=0.
- rst_n assertion mid-slot clears everything asynchronously. After deassertion, capture resumes only after a ws falling edge.

## Structure
- Package i2s_pkg:
  - state enum (IDLE, DELAY, SHIFT, HOLD)
  - mode constants MODE_I2S=0, MODE_LJ=1
  - width helper: counter width = $clog2(SLOT_BITS+1)
- Sub-module i2s_lane_shift: one per lane via generate. Holds a SAMPLE_BITS shift register plus left staging register, driven by shared shift_en/latch_left/latch_frame strobes from the control FSM.
- Control FSM, bit counter and flags exist once, in the top level.

## Test plan
Bench uses NUM_LINES=2, SAMPLE_BITS=8, SLOT_BITS=16.
- I2S mode, lane0 left 0xA5/right 0x3C, lane1 left 0x81/right 0x7E, out_ready=1 → one out_valid pulse; pcm_left=0x81A5, pcm_right=0x7E3C, 1 clk after right LSB.
- Same data, mode_lj=1, MSB driven on ws-edge cycle → identical words; out_valid one clk earlier relative to the ws edge.
- out_ready=0 for three frames → out_valid stays 1; pcm holds the third frame; overflow=1; clear_flags → overflow=0.
- ws toggles after 5 bits of a left slot → frame_err=1, no out_valid for that frame; next full frame delivered correctly.
- Start mid-right-slot after reset → first partial frame discarded; first out_valid only after a complete left+right pair.
- rst_n pulsed low during SHIFT → all outputs 0 immediately; enable=0 mid-frame → no out_valid until the next full frame after re-enable.
